display_arbiter: RTL and testbench

- Shares the six-digit seven-segment Output block between NUM_REQ requesters, e.g. CPU writeback, debug monitor and error codes.
- Drives Output's i_BUS / i_READ_BUS / i_CLEAR_n. Grants ownership round-robin and holds the strobe long enough for Output's divided clock to capture it.
- Keeps each owner on the display for a minimum hold time before another requester may take over.

---
 rtl/display_arbiter.sv | 124 ++++++++++++
 tb/tb_display_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the six-digit seven-segment Output block.
// Strobes the owner's snapshot onto Output, then holds it for a minimum display time.
module display_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter logic [31:0] STROBE_CYCLES = 32'h10000,
  parameter logic [31:0] HOLD_CYCLES   = 32'h02FAF080
) (
  input  logic                  i_SYS_CLOCK,
  input  logic                  i_RESET,
  input  logic [NUM_REQ-1:0]    i_REQ,
  input  logic [NUM_REQ*24-1:0] i_REQ_DATA,
  input  logic                  i_CLEAR_REQ,
  output logic [NUM_REQ-1:0]    o_GNT,
  output logic [31:0]           o_BUS,
  output logic                  o_READ_BUS,
  output logic                  o_CLEAR_n,
  output logic                  o_BUSY
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, own, own_n, nxt_ptr, base, win, go_idx;
  logic [31:0] cnt, cnt_n, bus_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [23:0] own_data;
  logic rd_n, clr_n, clr_q, found, go, refresh;

  // lowest offset from b (with wrap) that is requesting; MSB flags a hit
  function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] b);
    logic [IW:0] r;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(b) + k) % NUM_REQ]) r = {1'b1, IW'((int'(b) + k) % NUM_REQ)};
    return r;
  endfunction

  assign nxt_ptr  = (own == IW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
  assign base     = (state == HOLD) ? nxt_ptr : ptr;
  assign {found, win} = pick(i_REQ, base);
  assign own_data = i_REQ_DATA[24*int'(own) +: 24];
  // owner may only refresh its value when nobody else is waiting
  assign refresh  = i_REQ[own] && (own_data != o_BUS[23:0]) && !(|(i_REQ & ~o_GNT));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    own_n   = own;
    cnt_n   = cnt;
    gnt_n   = o_GNT;
    bus_n   = o_BUS;
    rd_n    = o_READ_BUS;
    clr_n   = 1'b1;
    go      = 1'b0;
    go_idx  = win;
    case (state)
      IDLE: go = found;
      LOAD: begin
        cnt_n = cnt - 32'd1;
        if (cnt == '0) begin
          rd_n    = 1'b0;
          state_n = HOLD;
          cnt_n   = HOLD_CYCLES - 32'd1;
        end
      end
      default: begin
        cnt_n = cnt - 32'd1;
        if (cnt == '0) begin
          ptr_n   = nxt_ptr;
          go      = found;
          state_n = found ? LOAD : IDLE;
          gnt_n   = '0;
        end else if (refresh) begin
          go     = 1'b1;
          go_idx = own;
        end
      end
    endcase
    if (go) begin
      state_n = LOAD;
      own_n   = go_idx;
      gnt_n   = NUM_REQ'(1) << go_idx;
      bus_n   = {8'h00, i_REQ_DATA[24*int'(go_idx) +: 24]};
      rd_n    = 1'b1;
      cnt_n   = STROBE_CYCLES - 32'd1;
    end
    // clear wins over everything; the low pulse fires only on the rising edge of the request
    if (i_CLEAR_REQ) begin
      state_n = IDLE;
      ptr_n   = ptr;
      own_n   = own;
      cnt_n   = '0;
      gnt_n   = '0;
      bus_n   = '0;
      rd_n    = 1'b0;
      clr_n   = clr_q;
    end
  end

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state      <= IDLE;
      ptr        <= '0;
      own        <= '0;
      cnt        <= '0;
      clr_q      <= 1'b0;
      o_GNT      <= '0;
      o_BUS      <= '0;
      o_READ_BUS <= 1'b0;
      o_CLEAR_n  <= 1'b1;
      o_BUSY     <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      own        <= own_n;
      cnt        <= cnt_n;
      clr_q      <= i_CLEAR_REQ;
      o_GNT      <= gnt_n;
      o_BUS      <= bus_n;
      o_READ_BUS <= rd_n;
      o_CLEAR_n  <= clr_n;
      o_BUSY     <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of display_arbiter with short strobe/hold times.
// A second instance covers the minimum-parameter configuration.
module tb_display_arbiter;
  logic clk, rst, clr;
  logic [3:0] req;
  logic [95:0] data;
  logic [3:0] gnt;
  logic [31:0] bus;
  logic rd, clrn, busy;
  logic [1:0] mreq, mgnt;
  logic [47:0] mdata;
  logic [31:0] mbus;
  logic mrd, mclrn, mbusy;
  int n_chk, n_fail;

  display_arbiter #(.NUM_REQ(4), .STROBE_CYCLES(32'd4), .HOLD_CYCLES(32'd10)) dut (
    .i_SYS_CLOCK(clk), .i_RESET(rst), .i_REQ(req), .i_REQ_DATA(data), .i_CLEAR_REQ(clr),
    .o_GNT(gnt), .o_BUS(bus), .o_READ_BUS(rd), .o_CLEAR_n(clrn), .o_BUSY(busy));

  display_arbiter #(.NUM_REQ(2), .STROBE_CYCLES(32'd1), .HOLD_CYCLES(32'd1)) dut_min (
    .i_SYS_CLOCK(clk), .i_RESET(rst), .i_REQ(mreq), .i_REQ_DATA(mdata), .i_CLEAR_REQ(1'b0),
    .o_GNT(mgnt), .o_BUS(mbus), .o_READ_BUS(mrd), .o_CLEAR_n(mclrn), .o_BUSY(mbusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; req = '0; mreq = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; req = '0; mreq = '0; data = '0; mdata = '0;
    step(); step();
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_chk++; if (bus !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 00000000", bus); end
    n_chk++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", rd); end
    n_chk++; if (clrn !== 1'b1) begin n_fail++; $display("FAIL reset_clrn: got %b want 1", clrn); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if ({mgnt, mrd, mclrn, mbusy} !== 5'b00010) begin n_fail++; $display("FAIL reset_min: got %b want 00010", {mgnt, mrd, mclrn, mbusy}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] eg;
    do_reset();
    req = 4'b0010; data = '0; data[47:24] = 24'h123456;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 1) req = '0;
      eg = (i <= 14) ? 4'b0010 : 4'b0000;
      n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL single_gnt cyc %0d: got %b want %b", i, gnt, eg); end
      n_chk++; if (rd !== (i <= 4)) begin n_fail++; $display("FAIL single_rd cyc %0d: got %b want %b", i, rd, (i <= 4)); end
      n_chk++; if (busy !== (i <= 14)) begin n_fail++; $display("FAIL single_busy cyc %0d: got %b want %b", i, busy, (i <= 14)); end
      n_chk++; if (bus !== 32'h00123456) begin n_fail++; $display("FAIL single_bus cyc %0d: got %h want 00123456", i, bus); end
    end
  endtask

  task automatic test_round_robin();
    int k;
    logic [3:0] eg;
    logic [31:0] eb;
    do_reset();
    data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    req = 4'b1111;
    for (int i = 1; i <= 57; i++) begin
      step();
      k = ((i - 1) / 14) % 4;
      eg = 4'b0001 << k;
      eb = {8'h00, {6{4'(k + 1)}}};
      n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt cyc %0d: got %b want %b", i, gnt, eg); end
      n_chk++; if (rd !== (((i - 1) % 14) < 4)) begin n_fail++; $display("FAIL rr_rd cyc %0d: got %b want %b", i, rd, (((i - 1) % 14) < 4)); end
      n_chk++; if (bus !== eb) begin n_fail++; $display("FAIL rr_bus cyc %0d: got %h want %h", i, bus, eb); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy cyc %0d: got %b want 1", i, busy); end
    end
    req = '0;
  endtask

  task automatic test_refresh();
    do_reset();
    data = '0; data[23:0] = 24'h111111; req = 4'b0001;
    for (int i = 1; i <= 6; i++) step();
    n_chk++; if (rd !== 1'b0) begin n_fail++; $display("FAIL refresh_hold_rd: got %b want 0", rd); end
    data[23:0] = 24'hABCDEF;
    step();
    n_chk++; if (rd !== 1'b1) begin n_fail++; $display("FAIL refresh_rd: got %b want 1", rd); end
    n_chk++; if (bus !== 32'h00ABCDEF) begin n_fail++; $display("FAIL refresh_bus: got %h want 00abcdef", bus); end
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL refresh_gnt: got %b want 0001", gnt); end
    step(); step(); step();
    n_chk++; if (rd !== 1'b1) begin n_fail++; $display("FAIL refresh_strobe_end: got %b want 1", rd); end
    step();
    n_chk++; if (rd !== 1'b0) begin n_fail++; $display("FAIL refresh_strobe_drop: got %b want 0", rd); end
    req = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    data = '0; data[23:0] = 24'h111111; data[71:48] = 24'h222222; req = 4'b0001;
    for (int i = 1; i <= 6; i++) step();
    data[23:0] = 24'hABCDEF; req = 4'b0101;
    step();
    n_chk++; if (rd !== 1'b0) begin n_fail++; $display("FAIL starve_rd: got %b want 0", rd); end
    n_chk++; if (bus !== 32'h00111111) begin n_fail++; $display("FAIL starve_bus: got %h want 00111111", bus); end
    for (int i = 8; i <= 14; i++) step();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL starve_hold_gnt: got %b want 0001", gnt); end
    step();
    n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL starve_gnt: got %b want 0100", gnt); end
    n_chk++; if (bus !== 32'h00222222) begin n_fail++; $display("FAIL starve_next_bus: got %h want 00222222", bus); end
    n_chk++; if (rd !== 1'b1) begin n_fail++; $display("FAIL starve_next_rd: got %b want 1", rd); end
    req = '0;
  endtask

  task automatic test_clear();
    do_reset();
    data = '0; data[23:0] = 24'h111111; data[95:72] = 24'h333333; req = 4'b0001;
    step();
    req = 4'b1001;
    for (int i = 2; i <= 14; i++) step();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL clear_pre_gnt: got %b want 0001", gnt); end
    clr = 1'b1; req = 4'b1000;
    step();
    n_chk++; if (clrn !== 1'b0) begin n_fail++; $display("FAIL clear_pulse: got %b want 0", clrn); end
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL clear_gnt: got %b want 0000", gnt); end
    n_chk++; if (bus !== 32'h0) begin n_fail++; $display("FAIL clear_bus: got %h want 00000000", bus); end
    n_chk++; if ({rd, busy} !== 2'b00) begin n_fail++; $display("FAIL clear_rd_busy: got %b want 00", {rd, busy}); end
    step();
    n_chk++; if (clrn !== 1'b1) begin n_fail++; $display("FAIL clear_one_cycle: got %b want 1", clrn); end
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL clear_held_gnt: got %b want 0000", gnt); end
    clr = 1'b0;
    step();
    n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL clear_after_gnt: got %b want 1000", gnt); end
    n_chk++; if (bus !== 32'h00333333) begin n_fail++; $display("FAIL clear_after_bus: got %h want 00333333", bus); end
    n_chk++; if (rd !== 1'b1) begin n_fail++; $display("FAIL clear_after_rd: got %b want 1", rd); end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    data = {24'h444444, 24'h333333, 24'h222222, 24'h111111}; req = 4'b0001;
    step();
    req = '0;
    for (int i = 2; i <= 15; i++) step();
    req = 4'b0011;
    step();
    n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL arst_pre_gnt: got %b want 0010", gnt); end
    step();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (rd !== 1'b0) begin n_fail++; $display("FAIL arst_rd: got %b want 0", rd); end
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL arst_gnt: got %b want 0000", gnt); end
    #1 rst = 1'b0;
    step();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL arst_ptr_gnt: got %b want 0001", gnt); end
    req = '0;
  endtask

  task automatic test_min_params();
    logic [1:0] eg;
    logic [31:0] eb;
    do_reset();
    mdata = {24'hBBBBBB, 24'hAAAAAA}; mreq = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      eg = (((i - 1) / 2) % 2 == 1) ? 2'b10 : 2'b01;
      eb = (eg == 2'b10) ? 32'h00BBBBBB : 32'h00AAAAAA;
      n_chk++; if (mgnt !== eg) begin n_fail++; $display("FAIL min_gnt cyc %0d: got %b want %b", i, mgnt, eg); end
      n_chk++; if (mrd !== (i % 2 == 1)) begin n_fail++; $display("FAIL min_rd cyc %0d: got %b want %b", i, mrd, (i % 2 == 1)); end
      n_chk++; if (mbus !== eb) begin n_fail++; $display("FAIL min_bus cyc %0d: got %h want %h", i, mbus, eb); end
    end
    mreq = '0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_refresh();
    test_starvation();
    test_clear();
    test_async_reset();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
